// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and receiver FSM states
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer for the serial line, resets to idle-high
module uart_sync (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic ff1_q, ff1_d;
    logic ff2_q, ff2_d;

    always_comb begin
        ff1_d = d;
        ff2_d = ff1_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ff1_q <= 1'b1;
            ff2_q <= 1'b1;
        end else begin
            ff1_q <= ff1_d;
            ff2_q <= ff2_d;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver (8N1) with held-byte handshake; overrun overwrite under UART_RX_OVERRUN_EN
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada,
    input  logic       ack,
    output logic [7:0] dado,
    output logic       valido,
    output logic       erro_quadro,
    output logic       sobrescrita,
    output logic       ocupado
);

    localparam int CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW     = $clog2(DATA_BITS);
    localparam int HALF_I = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CW-1:0] HALF     = CW'(HALF_I);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    logic rx_s;

    uart_sync u_sync (
        .clock (clock),
        .reset (reset),
        .d     (entrada),
        .q     (rx_s)
    );

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [7:0]           dado_q, dado_d;
    logic                 valido_q, valido_d;
    logic                 erro_q, erro_d;
    logic                 sobre_q, sobre_d;
    logic                 deliver, frame_err;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        deliver   = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                // The detection cycle is already cnt=0 of the start bit.
                if (!rx_s) begin
                    if (CLKS_PER_BIT == 1) begin
                        state_d = DATA;
                    end else begin
                        state_d = START;
                        cnt_d   = CW'(1);
                    end
                end
            end
            START: begin
                if ((HALF_I > 0) && (cnt_q == HALF) && rx_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == HALF) begin
                    shreg_d[idx_q] = rx_s;
                end
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // Leaving mid-stop-bit lets the next start edge be seen on time.
                if (cnt_q == HALF) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        dado_d   = dado_q;
        valido_d = valido_q;
        sobre_d  = sobre_q;
        erro_d   = frame_err;
        if (deliver) begin
            if (!valido_q || ack) begin
                dado_d   = shreg_q;
                valido_d = 1'b1;
                sobre_d  = 1'b0;
            end else begin
`ifdef UART_RX_OVERRUN_EN
                dado_d  = shreg_q;
                sobre_d = 1'b1;
`endif
            end
        end else if (valido_q && ack) begin
            valido_d = 1'b0;
            sobre_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            dado_q   <= '0;
            valido_q <= 1'b0;
            erro_q   <= 1'b0;
            sobre_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            dado_q   <= dado_d;
            valido_q <= valido_d;
            erro_q   <= erro_d;
            sobre_q  <= sobre_d;
        end
    end

    assign dado        = dado_q;
    assign valido      = valido_q;
    assign erro_quadro = erro_q;
    assign sobrescrita = sobre_q;
    assign ocupado     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx at CLKS_PER_BIT 16 and 1
module tb_uart_rx;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    logic line;
    logic ack_r;
    logic sel;

    logic       entrada16, entrada1, ack16, ack1;
    logic [7:0] dado16, dado1;
    logic       valido16, valido1, erro16, erro1, sobre16, sobre1, ocup16, ocup1;

    assign entrada16 = sel ? 1'b1 : line;
    assign entrada1  = sel ? line : 1'b1;
    assign ack16     = sel ? 1'b0 : ack_r;
    assign ack1      = sel ? ack_r : 1'b0;

    uart_rx #(.CLKS_PER_BIT(16)) dut16 (
        .clock(clock), .reset(reset), .entrada(entrada16), .ack(ack16),
        .dado(dado16), .valido(valido16), .erro_quadro(erro16),
        .sobrescrita(sobre16), .ocupado(ocup16)
    );

    uart_rx #(.CLKS_PER_BIT(1)) dut1 (
        .clock(clock), .reset(reset), .entrada(entrada1), .ack(ack1),
        .dado(dado1), .valido(valido1), .erro_quadro(erro1),
        .sobrescrita(sobre1), .ocupado(ocup1)
    );

    logic [7:0] d;
    logic       v, erro, ocup, sobre;
    assign d     = sel ? dado1   : dado16;
    assign v     = sel ? valido1 : valido16;
    assign erro  = sel ? erro1   : erro16;
    assign ocup  = sel ? ocup1   : ocup16;
    assign sobre = sel ? sobre1  : sobre16;

`ifdef UART_RX_OVERRUN_EN
    localparam logic [7:0] OVR_DADO  = 8'h22;
    localparam logic       OVR_SOBRE = 1'b1;
`else
    localparam logic [7:0] OVR_DADO  = 8'h11;
    localparam logic       OVR_SOBRE = 1'b0;
`endif

    int   tests = 0;
    int   fails = 0;
    int   edge_n = 0;
    int   rise_edge = -1;
    int   err_cnt = 0;
    int   busy_cnt = 0;
    int   force_ack_edge = -1;
    bit   auto_ack = 1'b0;
    logic prev_v = 1'b0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic       sel;
        logic [7:0] b;
        logic       stop;
        logic       exp_v;
        logic [7:0] exp_d;
        int         exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int bit_clks();
        return sel ? 1 : 16;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        edge_n++;
        if (v && !prev_v) rise_edge = edge_n;
        prev_v = v;
        if (erro) err_cnt++;
        if (ocup) busy_cnt++;
        if (auto_ack && v && !ack_r) begin
            got.push_back(d);
            ack_r = 1'b1;
        end else begin
            ack_r = (edge_n + 1 == force_ack_edge);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        #1;
        check("rst_valido", v, 1'b0);
        check("rst_ocupado", ocup, 1'b0);
        check("rst_dado", d, 8'h00);
        check("rst_sobre", sobre, 1'b0);
        repeat (n) tick();
        reset  = 1'b1;
        prev_v = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap_bits, input int abort_bit);
        int   n;
        logic bitv;
        n = bit_clks();
        for (int i = 0; i < 10; i++) begin
            bitv = (i == 0) ? 1'b0 : ((i == 9) ? stop : b[i-1]);
            line = bitv;
            for (int k = 0; k < n; k++) begin
                if (i == abort_bit && k == n / 2) begin
                    line = 1'b1;
                    do_reset(3);
                    return;
                end
                tick();
            end
        end
        line = 1'b1;
        repeat (gap_bits * n) tick();
    endtask

    task automatic ack_pulse();
        ack_r = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   start, n, exp_err, nfr, minsz;
        logic [7:0] b;
        logic stop;

        vecs[0] = '{1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 0};
        vecs[2] = '{1'b0, 8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        vecs[3] = '{1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 0};
        vecs[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1};
        vecs[5] = '{1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 0};
        vecs[6] = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1};
        vecs[7] = '{1'b0, 8'h5A, 1'b1, 1'b1, 8'h5A, 0};

        reset = 1'b0;
        line  = 1'b1;
        ack_r = 1'b0;
        sel   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_valido16", valido16, 1'b0);
        check("reset_ocupado16", ocup16, 1'b0);
        check("reset_dado16", dado16, 8'h00);
        check("reset_erro16", erro16, 1'b0);
        check("reset_sobre16", sobre16, 1'b0);
        check("reset_valido1", valido1, 1'b0);
        check("reset_ocupado1", ocup1, 1'b0);
        check("reset_dado1", dado1, 8'h00);
        reset = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < 8; i++) begin
            sel = vecs[i].sel;
            repeat (2) tick();
            n         = bit_clks();
            err_cnt   = 0;
            rise_edge = -1;
            start     = edge_n;
            send_frame(vecs[i].b, vecs[i].stop, vecs[i].sel ? 4 : 2, -1);
            check($sformatf("vec%0d_valido", i), v, vecs[i].exp_v);
            check($sformatf("vec%0d_erro_pulses", i), err_cnt, vecs[i].exp_err);
            check($sformatf("vec%0d_ocupado", i), ocup, 1'b0);
            if (vecs[i].exp_v) begin
                check($sformatf("vec%0d_dado", i), d, vecs[i].exp_d);
                check($sformatf("vec%0d_rise_edge", i), rise_edge - start, 3 + 9 * n + (n - 1) / 2);
                ack_pulse();
                check($sformatf("vec%0d_ack_clears", i), v, 1'b0);
            end
        end

        sel = 1'b1;
        repeat (2) tick();
        auto_ack = 1'b1;
        got.delete();
        err_cnt = 0;
        send_frame(8'h3C, 1'b1, 0, -1);
        send_frame(8'hFF, 1'b1, 5, -1);
        auto_ack = 1'b0;
        repeat (2) tick();
        check("b2b_count", got.size(), 2);
        if (got.size() == 2) begin
            check("b2b_first", got[0], 8'h3C);
            check("b2b_second", got[1], 8'hFF);
        end
        check("b2b_errors", err_cnt, 0);

        sel = 1'b0;
        repeat (2) tick();
        busy_cnt = 0;
        err_cnt  = 0;
        line = 1'b0;
        repeat (4) tick();
        line = 1'b1;
        repeat (40) tick();
        check("glitch_busy_seen", busy_cnt > 0, 1'b1);
        check("glitch_busy_max8", busy_cnt <= 8, 1'b1);
        check("glitch_valido", v, 1'b0);
        check("glitch_ocupado", ocup, 1'b0);
        check("glitch_erro", err_cnt, 0);

        send_frame(8'h11, 1'b1, 1, -1);
        send_frame(8'h22, 1'b1, 2, -1);
        check("ovr_valido", v, 1'b1);
        check("ovr_dado", d, OVR_DADO);
        check("ovr_sobre", sobre, OVR_SOBRE);
        ack_pulse();
        check("ovr_ack_valido", v, 1'b0);
        check("ovr_ack_sobre", sobre, 1'b0);
        ack_pulse();
        check("idle_ack_valido", v, 1'b0);
        check("idle_ack_dado", d, OVR_DADO);

        send_frame(8'h33, 1'b1, 1, -1);
        check("same_cycle_pre_valido", v, 1'b1);
        start = edge_n;
        force_ack_edge = start + 3 + 9 * 16 + 7;
        send_frame(8'h44, 1'b1, 2, -1);
        force_ack_edge = -1;
        check("same_cycle_valido", v, 1'b1);
        check("same_cycle_dado", d, 8'h44);
        check("same_cycle_sobre", sobre, 1'b0);
        ack_pulse();

        auto_ack = 1'b1;
        got.delete();
        err_cnt = 0;
        send_frame(8'h81, 1'b1, 0, 5);
        repeat (32) tick();
        send_frame(8'h42, 1'b1, 2, -1);
        repeat (4) tick();
        check("abort_count", got.size(), 1);
        if (got.size() == 1) check("abort_byte", got[0], 8'h42);
        check("abort_errors", err_cnt, 0);

        for (int s = 1; s >= 0; s--) begin
            sel = s[0];
            repeat (4) tick();
            got.delete();
            exp_q.delete();
            exp_err = 0;
            err_cnt = 0;
            nfr = sel ? 40 : 12;
            for (int f = 0; f < nfr; f++) begin
                b    = 8'($urandom);
                stop = sel ? ($urandom_range(0, 5) != 0) : 1'b1;
                if (stop) exp_q.push_back(b);
                else exp_err++;
                send_frame(b, stop, $urandom_range(0, 2), -1);
            end
            repeat (40) tick();
            check($sformatf("rand%0d_count", s), got.size(), exp_q.size());
            check($sformatf("rand%0d_errors", s), err_cnt, exp_err);
            minsz = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
            for (int k = 0; k < minsz; k++) begin
                check($sformatf("rand%0d_byte%0d", s, k), got[k], exp_q[k]);
            end
        end
        auto_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have a parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit; legal values are 1 or more.
REQ-002 The block SHALL have a port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have a port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have a port entrada, input, 1 bit: serial line; idle high; frame = start 0, 8 data bits LSB-first, stop 1.
REQ-005 The block SHALL have a port ack, input, 1 bit: consumer acknowledges the held byte.
REQ-006 The block SHALL have a port dado, output, 8 bits: last received byte.
REQ-007 The block SHALL have a port valido, output, 1 bit: dado holds an unacknowledged byte.
REQ-008 The block SHALL have a port erro_quadro, output, 1 bit: one-cycle pulse on stop-bit error.
REQ-009 The block SHALL have a port sobrescrita, output, 1 bit: sticky overrun flag.
REQ-010 The block SHALL have a port ocupado, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 entrada SHALL pass through a 2-flop synchronizer initialised to 1; the FSM SHALL use only the synchronized value rx_s.
REQ-012 The FSM SHALL have the states IDLE, START, DATA and STOP; HALF = (CLKS_PER_BIT-1)/2 with integer division; bit timer cnt runs 0..CLKS_PER_BIT-1.
REQ-013 In IDLE with rx_s=0, the detection cycle SHALL count as cnt=0 of the start bit; CLKS_PER_BIT=1 goes to DATA; otherwise the FSM goes to START with cnt=1.
REQ-014 In START, if HALF>0 and cnt==HALF and rx_s=1, the FSM SHALL treat it as a glitch and return to IDLE with no output; at cnt==CLKS_PER_BIT-1 it goes to DATA with cnt=0.
REQ-015 In DATA, at cnt==HALF, rx_s SHALL shift into bit position idx (LSB first); at cnt==CLKS_PER_BIT-1, idx increments; after idx=7 the FSM goes to STOP with cnt=0.
REQ-016 In STOP at cnt==HALF, the FSM SHALL return to IDLE in the same cycle, which allows back-to-back frames; rx_s=1 delivers the byte; rx_s=0 pulses erro_quadro for 1 cycle and discards the byte.
REQ-017 On delivery, dado and valido SHALL be updated on the clock edge after the stop sample; valido stays 1 until ack=1 is sampled, then clears on the next edge.
REQ-018 If ack and a delivery occur in the same cycle, the new byte SHALL win: valido stays 1, dado is updated and no overrun is flagged.
REQ-019 ack while valido=0 SHALL have no effect.

Reset
REQ-020 While reset=0, the block SHALL be in IDLE with cnt=0, idx=0, synchronizer flops=1, dado=0, valido=0, erro_quadro=0, sobrescrita=0 and ocupado=0.
REQ-021 Reset asserted mid-frame SHALL abort the frame without delivering a byte; after release, the block waits for a fresh falling edge on rx_s.

Configuration
REQ-022 With macro UART_RX_OVERRUN_EN defined, a delivery while valido=1 and ack=0 SHALL overwrite dado and set sobrescrita; sobrescrita clears together with valido on ack.
REQ-023 Without UART_RX_OVERRUN_EN, a delivery while valido=1 and ack=0 SHALL be dropped: dado is kept and sobrescrita is tied to 0.

Structure
REQ-024 Package uart_pkg SHALL hold the FSM state enum, DATA_BITS=8 and FRAME_BITS=10, shared with the transmitter.
REQ-025 The synchronizer SHALL be a sub-module named uart_sync (2 flops, reset value 1); the FSM, timer and output register stay in uart_rx.

Verification
REQ-026 The bench SHALL cover: CLKS_PER_BIT=16, send frame 0xA5 -> valido rises 1 cycle after the stop sample, dado=0xA5, erro_quadro=0.
REQ-027 The bench SHALL cover: CLKS_PER_BIT=1, driven by the transmitter one bit per clock with 0x3C, then 0xFF back-to-back -> dado=0x3C acked, then dado=0xFF, no errors.
REQ-028 The bench SHALL cover: CLKS_PER_BIT=16, 4-cycle low glitch on the idle line -> return to IDLE, valido stays 0, ocupado high for at most 8 cycles.
REQ-029 The bench SHALL cover: frame 0x55 with stop bit driven 0 -> erro_quadro pulses once, valido stays 0.
REQ-030 The bench SHALL cover: frames 0x11 then 0x22 with no ack -> with UART_RX_OVERRUN_EN: dado=0x22, sobrescrita=1; without it: dado=0x11, sobrescrita=0.
REQ-031 The bench SHALL cover: reset asserted during data bit 4 of 0x81, then 0x42 sent -> only 0x42 is delivered.
